// File: rtl/hazard_ctrl_if.sv
// Pipeline-facing hazard signals and the register enable/flush controls they produce.
// The pipeline datapath is the master; hazard_ctrl is the slave.
interface hazard_ctrl_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs1;
    logic       id_use_rs2;
    logic [4:0] ex_rd;
    logic       ex_rd_eq0;
    logic       ex_mem_read;
    logic       ex_redirect;
    logic       mem_req;
    logic       dmem_ready;
    logic       imem_ready;
    logic       pc_en;
    logic       if_id_en;
    logic       id_ex_en;
    logic       ex_mem_en;
    logic       if_id_flush;
    logic       id_ex_flush;

    modport master (
        output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_rd_eq0,
               ex_mem_read, ex_redirect, mem_req, dmem_ready, imem_ready,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush
    );

    modport slave (
        input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_rd_eq0,
               ex_mem_read, ex_redirect, mem_req, dmem_ready, imem_ready,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage core: load-use bubbles, redirect
// flushes, instruction/data memory wait states and saturating stall/flush counters.
module hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    hazard_ctrl_if.slave     hz,
    input  logic             cnt_clr,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [1:0]       state_o
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DSTALL = 2'd1,
        FLUSH2 = 2'd2
    } state_t;

    localparam logic [15:0]      TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t      state;
    state_t      state_nx;
    logic [15:0] tcnt;
    logic        lu;
    logic        ds;
    logic        hold_all;
    logic        run_rules;
    logic        flush_evt;
    logic        pc_en;
    logic        if_id_en;
    logic        id_ex_en;
    logic        ex_mem_en;
    logic        if_id_flush;
    logic        id_ex_flush;

    // Controls are combinational so the pipeline registers react in the same cycle.
    always_comb begin
        lu = hz.ex_mem_read & ~hz.ex_rd_eq0 &
             ((hz.id_use_rs1 & (hz.id_rs1 == hz.ex_rd)) |
              (hz.id_use_rs2 & (hz.id_rs2 == hz.ex_rd)));
        ds          = hz.mem_req & ~hz.dmem_ready;
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        mem_err     = 1'b0;
        flush_evt   = 1'b0;
        hold_all    = 1'b0;
        run_rules   = 1'b0;
        state_nx    = RUN;

        case (state)
            RUN: begin
                if (ds) begin
                    hold_all = 1'b1;
                    state_nx = DSTALL;
                end else begin
                    run_rules = 1'b1;
                end
            end
            DSTALL: begin
                if (hz.dmem_ready) begin
                    run_rules = 1'b1;
                end else if (tcnt == TMO_LAST) begin
                    mem_err = 1'b1;
                end else begin
                    hold_all = 1'b1;
                    state_nx = DSTALL;
                end
            end
            FLUSH2: begin
                if (ds) begin
                    hold_all = 1'b1;
                    state_nx = DSTALL;
                end else begin
                    if_id_flush = 1'b1;
                    flush_evt   = 1'b1;
                end
            end
            default: begin
                hold_all    = 1'b1;
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end
        endcase

        if (hold_all) begin
            pc_en     = 1'b0;
            if_id_en  = 1'b0;
            id_ex_en  = 1'b0;
            ex_mem_en = 1'b0;
        end

        // Redirect beats load-use, which beats a missing fetch.
        if (run_rules) begin
            if (hz.ex_redirect) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                flush_evt   = 1'b1;
                state_nx    = FLUSH2;
            end else if (lu) begin
                pc_en       = 1'b0;
                if_id_en    = 1'b0;
                id_ex_flush = 1'b1;
            end else if (!hz.imem_ready) begin
                pc_en       = 1'b0;
                if_id_flush = 1'b1;
            end
        end

        if (!rstn) begin
            pc_en       = 1'b0;
            if_id_en    = 1'b0;
            id_ex_en    = 1'b0;
            ex_mem_en   = 1'b0;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            mem_err     = 1'b0;
        end
    end

    assign hz.pc_en       = pc_en;
    assign hz.if_id_en    = if_id_en;
    assign hz.id_ex_en    = id_ex_en;
    assign hz.ex_mem_en   = ex_mem_en;
    assign hz.if_id_flush = if_id_flush;
    assign hz.id_ex_flush = id_ex_flush;
    assign state_o        = state;

    // The timeout counter sits at zero outside DSTALL, so every entry starts fresh.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state     <= RUN;
            tcnt      <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nx;
            if (state == DSTALL) begin
                tcnt <= tcnt + 16'd1;
            end else begin
                tcnt <= '0;
            end
            if (cnt_clr) begin
                stall_cnt <= '0;
                flush_cnt <= '0;
            end else begin
                if (!pc_en && (stall_cnt != '1)) begin
                    stall_cnt <= stall_cnt + CNT_ONE;
                end
                if (flush_evt && (flush_cnt != '1)) begin
                    flush_cnt <= flush_cnt + CNT_ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: a vector table and directed corner sequences,
// then random traffic against a rule-level reference model on a small-parameter instance.
module tb_hazard_ctrl;
    localparam int TMO_B = 3;
    localparam int CW_B  = 4;
    localparam int SAT_B = (1 << CW_B) - 1;
    localparam int NV    = 13;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       use1;
        logic       use2;
        logic [4:0] rd;
        logic       rd0;
        logic       mrd;
        logic       redir;
        logic       mreq;
        logic       dready;
        logic       iready;
    } stim_t;

    typedef struct {
        stim_t      s;
        logic [5:0] ctl;
        logic [1:0] nxt;
    } vec_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            cnt_clr;
    logic            mem_err_a;
    logic            mem_err_b;
    logic [31:0]     stall_a;
    logic [31:0]     flush_a;
    logic [CW_B-1:0] stall_b;
    logic [CW_B-1:0] flush_b;
    logic [1:0]      state_a;
    logic [1:0]      state_b;
    int              checks   = 0;
    int              failures = 0;

    bit m_waiting;
    bit m_squash;
    int m_waited;
    int m_stalls;
    int m_flushes;

    vec_t tbl [NV];

    hazard_ctrl_if hz_a ();
    hazard_ctrl_if hz_b ();

    assign hz_b.id_rs1      = hz_a.id_rs1;
    assign hz_b.id_rs2      = hz_a.id_rs2;
    assign hz_b.id_use_rs1  = hz_a.id_use_rs1;
    assign hz_b.id_use_rs2  = hz_a.id_use_rs2;
    assign hz_b.ex_rd       = hz_a.ex_rd;
    assign hz_b.ex_rd_eq0   = hz_a.ex_rd_eq0;
    assign hz_b.ex_mem_read = hz_a.ex_mem_read;
    assign hz_b.ex_redirect = hz_a.ex_redirect;
    assign hz_b.mem_req     = hz_a.mem_req;
    assign hz_b.dmem_ready  = hz_a.dmem_ready;
    assign hz_b.imem_ready  = hz_a.imem_ready;

    hazard_ctrl dut_a (
        .clk       (clk),
        .rstn      (rstn),
        .hz        (hz_a),
        .cnt_clr   (cnt_clr),
        .mem_err   (mem_err_a),
        .stall_cnt (stall_a),
        .flush_cnt (flush_a),
        .state_o   (state_a)
    );

    hazard_ctrl #(.TIMEOUT(TMO_B), .CNT_W(CW_B)) dut_b (
        .clk       (clk),
        .rstn      (rstn),
        .hz        (hz_b),
        .cnt_clr   (cnt_clr),
        .mem_err   (mem_err_b),
        .stall_cnt (stall_b),
        .flush_cnt (flush_b),
        .state_o   (state_b)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic stim_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic use1, input logic use2, input logic [4:0] rd,
                                 input logic rd0, input logic mrd, input logic redir,
                                 input logic mreq, input logic dready, input logic iready);
        stim_t s;
        s.rs1 = rs1; s.rs2 = rs2; s.use1 = use1; s.use2 = use2; s.rd = rd; s.rd0 = rd0;
        s.mrd = mrd; s.redir = redir; s.mreq = mreq; s.dready = dready; s.iready = iready;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    endfunction

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush}
    function automatic logic [5:0] ctl_a();
        return {hz_a.pc_en, hz_a.if_id_en, hz_a.id_ex_en, hz_a.ex_mem_en,
                hz_a.if_id_flush, hz_a.id_ex_flush};
    endfunction

    function automatic logic [5:0] ctl_b();
        return {hz_b.pc_en, hz_b.if_id_en, hz_b.id_ex_en, hz_b.ex_mem_en,
                hz_b.if_id_flush, hz_b.id_ex_flush};
    endfunction

    task automatic applyStimulus(input stim_t s);
        hz_a.id_rs1      = s.rs1;
        hz_a.id_rs2      = s.rs2;
        hz_a.id_use_rs1  = s.use1;
        hz_a.id_use_rs2  = s.use2;
        hz_a.ex_rd       = s.rd;
        hz_a.ex_rd_eq0   = s.rd0;
        hz_a.ex_mem_read = s.mrd;
        hz_a.ex_redirect = s.redir;
        hz_a.mem_req     = s.mreq;
        hz_a.dmem_ready  = s.dready;
        hz_a.imem_ready  = s.iready;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rstn    = 1'b0;
        cnt_clr = 1'b0;
        applyStimulus(idle());
        tick();
        tick();
        rstn = 1'b1;
    endtask

    // Reference model: tracks "data access outstanding", "wrong-path fetch still due"
    // and cycles waited, and derives each cycle's controls straight from the hazard rules.
    task automatic modelStep(input stim_t s, input logic rst, input logic clr,
                             output logic [5:0] ctl, output logic err);
        bit lu;
        bit flush_evt;
        lu = s.mrd && !s.rd0 && ((s.use1 && s.rs1 == s.rd) || (s.use2 && s.rs2 == s.rd));
        err       = 1'b0;
        flush_evt = 1'b0;
        ctl       = 6'b111100;
        if (!rst) begin
            ctl       = 6'b000011;
            m_waiting = 1'b0;
            m_squash  = 1'b0;
            m_waited  = 0;
            m_stalls  = 0;
            m_flushes = 0;
            return;
        end
        if (m_waiting && !s.dready) begin
            m_waited++;
            if (m_waited == TMO_B) begin
                err       = 1'b1;
                m_waiting = 1'b0;
            end else begin
                ctl = 6'b000000;
            end
        end else if (!m_waiting && s.mreq && !s.dready) begin
            ctl       = 6'b000000;
            m_waiting = 1'b1;
            m_waited  = 0;
            m_squash  = 1'b0;
        end else if (!m_waiting && m_squash) begin
            ctl       = 6'b111110;
            flush_evt = 1'b1;
            m_squash  = 1'b0;
        end else begin
            m_waiting = 1'b0;
            if (s.redir) begin
                ctl       = 6'b111111;
                flush_evt = 1'b1;
                m_squash  = 1'b1;
            end else if (lu) begin
                ctl = 6'b001101;
            end else if (!s.iready) begin
                ctl = 6'b011110;
            end
        end
        if (clr) begin
            m_stalls  = 0;
            m_flushes = 0;
        end else begin
            if (!ctl[5] && m_stalls < SAT_B) m_stalls++;
            if (flush_evt && m_flushes < SAT_B) m_flushes++;
        end
    endtask

    initial begin
        stim_t      rs;
        stim_t      ds_s;
        logic [5:0] ectl;
        logic       eerr;
        logic       rr;
        logic       cc;
        int         est;

        //                rs1 rs2 u1 u2 rd rd0 mrd red mreq drdy irdy
        tbl[0]  = '{mk(5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0, 0, 1, 1), 6'b111100, 2'd0};
        tbl[1]  = '{mk(5'd5, 5'd2, 1, 0, 5'd5, 0, 1, 0, 0, 1, 1), 6'b001101, 2'd0};
        tbl[2]  = '{mk(5'd1, 5'd7, 0, 1, 5'd7, 0, 1, 0, 0, 1, 1), 6'b001101, 2'd0};
        tbl[3]  = '{mk(5'd0, 5'd2, 1, 0, 5'd0, 1, 1, 0, 0, 1, 1), 6'b111100, 2'd0};
        tbl[4]  = '{mk(5'd5, 5'd2, 0, 0, 5'd5, 0, 1, 0, 0, 1, 1), 6'b111100, 2'd0};
        tbl[5]  = '{mk(5'd5, 5'd5, 1, 1, 5'd5, 0, 0, 0, 0, 1, 1), 6'b111100, 2'd0};
        tbl[6]  = '{mk(5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 0, 1, 0), 6'b011110, 2'd0};
        tbl[7]  = '{mk(5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 1, 0, 1, 1), 6'b111111, 2'd2};
        tbl[8]  = '{mk(5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0, 1, 0, 1), 6'b000000, 2'd1};
        tbl[9]  = '{mk(5'd5, 5'd2, 1, 0, 5'd5, 0, 1, 1, 1, 0, 0), 6'b000000, 2'd1};
        tbl[10] = '{mk(5'd5, 5'd2, 1, 0, 5'd5, 0, 1, 0, 1, 1, 1), 6'b001101, 2'd0};
        tbl[11] = '{mk(5'd5, 5'd2, 1, 0, 5'd5, 0, 1, 1, 0, 1, 1), 6'b111111, 2'd2};
        tbl[12] = '{mk(5'd5, 5'd2, 1, 0, 5'd5, 0, 1, 0, 0, 1, 0), 6'b001101, 2'd0};
        ds_s    = mk(5'd1, 5'd2, 0, 0, 5'd3, 0, 0, 0, 1, 0, 1);

        // Reset values
        rstn    = 1'b0;
        cnt_clr = 1'b0;
        applyStimulus(idle());
        checkOutput("reset_ctl_a", 32'(ctl_a()), 32'(6'b000011));
        checkOutput("reset_ctl_b", 32'(ctl_b()), 32'(6'b000011));
        checkOutput("reset_err", 32'(mem_err_a), 32'd0);
        tick();
        tick();
        checkOutput("reset_state", 32'(state_a), 32'd0);
        checkOutput("reset_stall", stall_a, 32'd0);
        checkOutput("reset_flush", flush_a, 32'd0);
        rstn = 1'b1;
        #1;
        checkOutput("post_reset_ctl", 32'(ctl_a()), 32'(6'b111100));

        for (int i = 0; i < NV; i++) begin
            doReset();
            applyStimulus(tbl[i].s);
            checkOutput($sformatf("vec%0d_ctl", i), 32'(ctl_a()), 32'(tbl[i].ctl));
            checkOutput($sformatf("vec%0d_err", i), 32'(mem_err_a), 32'd0);
            tick();
            checkOutput($sformatf("vec%0d_state", i), 32'(state_a), 32'(tbl[i].nxt));
        end

        // Load-use costs exactly one cycle
        doReset();
        applyStimulus(tbl[1].s);
        checkOutput("lu_ctl", 32'(ctl_a()), 32'(6'b001101));
        tick();
        applyStimulus(idle());
        checkOutput("lu_after_ctl", 32'(ctl_a()), 32'(6'b111100));
        checkOutput("lu_stall1", stall_a, 32'd1);
        tick();
        checkOutput("lu_stall_hold", stall_a, 32'd1);

        // Redirect followed by FLUSH2
        doReset();
        applyStimulus(tbl[7].s);
        checkOutput("redir_ctl", 32'(ctl_a()), 32'(6'b111111));
        tick();
        applyStimulus(idle());
        checkOutput("redir_f2_state", 32'(state_a), 32'd2);
        checkOutput("redir_f2_ctl", 32'(ctl_a()), 32'(6'b111110));
        tick();
        checkOutput("redir_run_state", 32'(state_a), 32'd0);
        checkOutput("redir_run_ctl", 32'(ctl_a()), 32'(6'b111100));
        checkOutput("redir_flush_cnt", flush_a, 32'd2);

        // Data wait of four cycles, then ready
        doReset();
        applyStimulus(ds_s);
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("dwait%0d_ctl", k), 32'(ctl_a()), 32'd0);
            checkOutput($sformatf("dwait%0d_state", k), 32'(state_a), (k == 0) ? 32'd0 : 32'd1);
            checkOutput($sformatf("dwait%0d_err", k), 32'(mem_err_a), 32'd0);
            tick();
        end
        rs = ds_s;
        rs.dready = 1'b1;
        applyStimulus(rs);
        checkOutput("dwait_ready_state", 32'(state_a), 32'd1);
        checkOutput("dwait_ready_ctl", 32'(ctl_a()), 32'(6'b111100));
        checkOutput("dwait_ready_err", 32'(mem_err_a), 32'd0);
        tick();
        applyStimulus(idle());
        checkOutput("dwait_done_state", 32'(state_a), 32'd0);
        checkOutput("dwait_stall_cnt", stall_a, 32'd4);

        // DS, redirect and load-use together
        doReset();
        rs = tbl[9].s;
        applyStimulus(rs);
        checkOutput("all3_ctl", 32'(ctl_a()), 32'd0);
        tick();
        checkOutput("all3_state", 32'(state_a), 32'd1);
        rs.dready = 1'b1;
        rs.iready = 1'b1;
        applyStimulus(rs);
        checkOutput("all3_ready_ctl", 32'(ctl_a()), 32'(6'b111111));
        tick();
        applyStimulus(idle());
        checkOutput("all3_f2_state", 32'(state_a), 32'd2);
        checkOutput("all3_f2_ctl", 32'(ctl_a()), 32'(6'b111110));
        tick();
        checkOutput("all3_run_state", 32'(state_a), 32'd0);

        // Reset during DSTALL
        doReset();
        applyStimulus(ds_s);
        tick();
        tick();
        checkOutput("rst_ds_pre_state", 32'(state_a), 32'd1);
        rstn = 1'b0;
        #1;
        checkOutput("rst_ds_ctl", 32'(ctl_a()), 32'(6'b000011));
        checkOutput("rst_ds_err", 32'(mem_err_a), 32'd0);
        tick();
        checkOutput("rst_ds_state", 32'(state_a), 32'd0);
        checkOutput("rst_ds_stall", stall_a, 32'd0);
        rstn = 1'b1;

        // Timeout with TIMEOUT=3: mem_err on the third DSTALL cycle
        doReset();
        applyStimulus(ds_s);
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("tmo%0d_err", k), 32'(mem_err_b), 32'd0);
            tick();
        end
        checkOutput("tmo_err", 32'(mem_err_b), 32'd1);
        checkOutput("tmo_ctl", 32'(ctl_b()), 32'(6'b111100));
        tick();
        checkOutput("tmo_state", 32'(state_b), 32'd0);
        checkOutput("tmo_err_gone", 32'(mem_err_b), 32'd0);

        // Reset landing on the timeout cycle suppresses mem_err
        doReset();
        applyStimulus(ds_s);
        tick();
        tick();
        tick();
        rstn = 1'b0;
        #1;
        checkOutput("tmo_rst_err", 32'(mem_err_b), 32'd0);
        tick();
        checkOutput("tmo_rst_state", 32'(state_b), 32'd0);
        rstn = 1'b1;

        // Saturation at 15 with CNT_W=4, then clear beating increment
        doReset();
        rs = idle();
        rs.iready = 1'b0;
        applyStimulus(rs);
        for (int k = 0; k < 20; k++) tick();
        checkOutput("sat_stall", 32'(stall_b), 32'd15);
        cnt_clr = 1'b1;
        #1;
        tick();
        checkOutput("clr_stall", 32'(stall_b), 32'd0);
        cnt_clr = 1'b0;
        tick();
        checkOutput("clr_then_inc", 32'(stall_b), 32'd1);

        // Random traffic against the reference model
        doReset();
        m_waiting = 1'b0;
        m_squash  = 1'b0;
        m_waited  = 0;
        m_stalls  = 0;
        m_flushes = 0;
        for (int n = 0; n < 3000; n++) begin
            rs.rs1    = 5'($urandom_range(0, 3));
            rs.rs2    = 5'($urandom_range(0, 3));
            rs.use1   = 1'($urandom_range(0, 1));
            rs.use2   = 1'($urandom_range(0, 1));
            rs.rd     = 5'($urandom_range(0, 3));
            rs.rd0    = (rs.rd == 5'd0);
            rs.mrd    = 1'($urandom_range(0, 1));
            rs.redir  = ($urandom_range(0, 5) == 0) && !(m_squash && !m_waiting);
            rs.mreq   = ($urandom_range(0, 2) == 0);
            rs.dready = 1'($urandom_range(0, 1));
            rs.iready = ($urandom_range(0, 3) != 0);
            rr        = ($urandom_range(0, 59) != 0);
            cc        = ($urandom_range(0, 39) == 0);
            rstn      = rr;
            cnt_clr   = cc;
            applyStimulus(rs);
            modelStep(rs, rr, cc, ectl, eerr);
            checkOutput($sformatf("rnd%0d_ctl", n), 32'(ctl_b()), 32'(ectl));
            checkOutput($sformatf("rnd%0d_err", n), 32'(mem_err_b), 32'(eerr));
            tick();
            est = m_waiting ? 1 : (m_squash ? 2 : 0);
            checkOutput($sformatf("rnd%0d_state", n), 32'(state_b), 32'(est));
            checkOutput($sformatf("rnd%0d_stall", n), 32'(stall_b), 32'(m_stalls));
            checkOutput($sformatf("rnd%0d_flush", n), 32'(flush_b), 32'(m_flushes));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the five-stage RISC-V Lite core. It drives the enable and flush inputs of the PC, IF/ID, ID/EX and EX/MEM registers. It consumes the ID-stage source operands and the ID/EX-stage destination and control outputs, and is the control-side counterpart of the ID/EX pipeline register. It resolves load-use hazards, taken-branch/jump flushes, and instruction/data memory wait states, and keeps saturating performance counters.

## Interface
- TIMEOUT, 255: maximum DSTALL cycles before abort; valid range 1..65535.
- CNT_W, 32: performance counter width.
- clk  in  1  core clock.
- rstn  in  1  synchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_use_rs1, id_use_rs2  in  1 each  ID instruction reads rs1 / rs2.
- ex_rd  in  5  Rd held in ID/EX.
- ex_rd_eq0  in  1  ID/EX Rd is x0.
- ex_mem_read  in  1  ID/EX instruction is a load.
- ex_redirect  in  1  branch taken or jump resolved in EX this cycle.
- mem_req  in  1  EX/MEM instruction accesses data memory.
- dmem_ready  in  1  data memory completes the access this cycle.
- imem_ready  in  1  instruction memory returns a valid fetch this cycle.
- cnt_clr  in  1  synchronously clears both counters.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register enables.
- if_id_flush, id_ex_flush  out  1 each  load NOP/bubble into the register (ID/EX bubble: WB=0, M.CS=1, branch/MemRead/jump=0).
- mem_err  out  1  one-cycle pulse on DSTALL timeout.
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.
- state_o  out  2  current FSM state, for debug.

## Operation
- FSM states: RUN=0, DSTALL=1, FLUSH2=2. The encoding value 3 is illegal and recovers to RUN on the next clock.
- Load-use hazard (LU) = ex_mem_read & !ex_rd_eq0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
- Priority in RUN is applied in this order:
  - DS = mem_req & !dmem_ready:
    - All four enables 0, no flush, next state DSTALL.
  - ex_redirect:
    - pc_en=1, if_id_flush=1, id_ex_flush=1, all enables 1.
    - Next state FLUSH2, which squashes the wrong-path fetch still returning.
  - LU:
    - pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1. Exactly one bubble is inserted.
  - !imem_ready:
    - pc_en=0, if_id_flush=1. ID/EX and EX/MEM advance with their enables at 1.
  - Otherwise all enables 1, flushes 0.
- DSTALL:
  - All enables 0 and flushes 0 while dmem_ready=0.
  - The cycle dmem_ready=1: behave as RUN with DS=0, using the same cycle's LU, ex_redirect and imem_ready, and return to RUN or FLUSH2.
  - A timeout counter increments every DSTALL cycle. When it reaches TIMEOUT:
    - mem_err=1 for that cycle and all enables 1, which drops the access.
    - Next state RUN.
  - The timeout counter clears on DSTALL entry.
- FLUSH2:
  - if_id_flush=1, all enables 1, next state RUN.
  - DS in FLUSH2 takes priority exactly as in RUN.
  - A new ex_redirect in FLUSH2 is impossible, because ID/EX holds a bubble.
- Flush overrides enable: when a flush is 1, the target register loads a NOP regardless of its enable.
- Counters:
  - stall_cnt increments on every cycle with pc_en=0.
  - flush_cnt increments on every cycle with id_ex_flush=1 due to ex_redirect, or with if_id_flush=1 in FLUSH2. It increments at most once per cycle.
  - Both saturate at 2^CNT_W−1. cnt_clr has priority over increment.

## Timing
- Enables, flushes and mem_err are combinational from the state and current inputs, with zero-cycle latency to the pipeline registers. The state and counters are registered.
- During rstn=0:
  - State becomes RUN, the timeout counter, stall_cnt and flush_cnt become 0, and mem_err=0.
  - Enables are forced 0 and if_id_flush=id_ex_flush=1, so the pipeline holds NOPs.
- Outputs take RUN behaviour on the first clock after rstn rises.
- Reset asserted mid-DSTALL or mid-FLUSH2 aborts to RUN with no mem_err pulse.
- A load-use hazard costs exactly 1 cycle; a redirect costs 2 cycles (the redirect cycle plus FLUSH2).
- A DSTALL lasting N cycles costs N+0 additional cycles beyond the ready cycle.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 for 1 cycle -> pc_en=0, if_id_en=0, id_ex_flush=1 for exactly that cycle; stall_cnt=1. Repeat with ex_rd_eq0=1, or with id_use_rs1=0 -> no stall.
- Redirect: ex_redirect pulse -> that cycle id_ex_flush=if_id_flush=1; next cycle state_o=2 with if_id_flush=1; then RUN; flush_cnt=2.
- Data wait: mem_req=1, dmem_ready=0 for 4 cycles, then 1 -> all enables 0 for 4 cycles, state_o=1, then resume; stall_cnt=4; mem_err never asserted.
- Timeout: TIMEOUT=3, dmem_ready held 0 -> mem_err pulses on the 3rd DSTALL cycle, state returns to RUN.
- Simultaneous DS, ex_redirect and LU -> DSTALL taken first. On the ready cycle the redirect flush wins and LU is ignored; then FLUSH2.
- Reset mid-DSTALL, and saturation: rstn=0 in DSTALL -> outputs take their reset values, state 0, no mem_err. With CNT_W=4 and 20 stall cycles -> stall_cnt=15. cnt_clr together with an increment -> 0.
